// File: rtl/keccak_hash_arbiter_if.sv
// Requester and hash-core handshake bundle for keccak_hash_arbiter.
// slave = arbiter side, master = requesters/core side.
interface keccak_hash_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 512,
  parameter int HASH_W  = 256
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [HASH_W-1:0]         rsp_hash;
  logic                      rsp_err;
  logic                      core_start;
  logic [DATA_W-1:0]         core_data;
  logic                      core_done;
  logic [HASH_W-1:0]         core_hash;

  modport slave (
    input  req_valid, req_data, rsp_ready, core_done, core_hash,
    output req_ready, rsp_valid, rsp_hash, rsp_err, core_start, core_data
  );

  modport master (
    output req_valid, req_data, rsp_ready, core_done, core_hash,
    input  req_ready, rsp_valid, rsp_hash, rsp_err, core_start, core_data
  );
endinterface

// File: rtl/keccak_hash_arbiter.sv
// Round-robin sharing of one Keccak-256 core between NUM_REQ requesters,
// with a start/done handshake to the core and a timeout watchdog.
module keccak_hash_arbiter_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic [IDW-1:0] sel_id,
  input  logic [IDW-1:0] grant_id,
  input  logic           accept_en,
  input  logic           respond,
  output logic           req_ready,
  output logic           rsp_valid
);
  assign req_ready = accept_en && (sel_id == IDW'(LANE));
  assign rsp_valid = respond && (grant_id == IDW'(LANE));
endmodule

module keccak_hash_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 512,
  parameter int HASH_W  = 256,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  keccak_hash_arbiter_if.slave  bus,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t                          state, state_nxt;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_blk;
  logic [IDW-1:0]                  rr_ptr, sel_id;
  logic                            sel_vld;
  logic [CNT_W-1:0]                tmo_cnt;
  logic                            tmo_hit;
  logic                            accept_en, respond, core_start;
  logic [DATA_W-1:0]               core_data_q;
  logic [HASH_W-1:0]               rsp_hash_q;
  logic                            rsp_err_q;
  logic [NUM_REQ-1:0]              req_rdy, rsp_vld;

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  assign req_blk = bus.req_data;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Walk offsets high to low so the closest valid requester at/after rr_ptr wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_next(rr_ptr, k)]) begin
        sel_vld = 1'b1;
        sel_id  = rr_next(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      tmo_cnt     <= '0;
      core_data_q <= '0;
      rsp_hash_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: if (sel_vld) begin
          core_data_q <= req_blk[sel_id];
          grant_id    <= sel_id;
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // done beats the watchdog when both land in the same cycle
          if (bus.core_done) begin
            rsp_hash_q <= bus.core_hash;
            rsp_err_q  <= 1'b0;
          end else if (tmo_hit) begin
            rsp_hash_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        S_RESPOND: if (bus.rsp_ready[grant_id]) rr_ptr <= rr_next(grant_id, 1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    accept_en  = 1'b0;
    respond    = 1'b0;
    core_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy      = 1'b0;
        // gating with rst_n keeps req_ready low while reset is held
        accept_en = sel_vld && rst_n;
        if (sel_vld) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        core_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: if (bus.core_done || tmo_hit) state_nxt = S_RESPOND;
      S_RESPOND: begin
        respond = 1'b1;
        if (bus.rsp_ready[grant_id]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    keccak_hash_arbiter_lane #(.IDW(IDW), .LANE(g)) u_lane (
      .sel_id    (sel_id),
      .grant_id  (grant_id),
      .accept_en (accept_en),
      .respond   (respond),
      .req_ready (req_rdy[g]),
      .rsp_valid (rsp_vld[g])
    );
  end

  assign bus.req_ready  = req_rdy;
  assign bus.rsp_valid  = rsp_vld;
  assign bus.rsp_hash   = rsp_hash_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.core_start = core_start;
  assign bus.core_data  = core_data_q;
endmodule

// File: tb/tb_keccak_hash_arbiter.sv
// Randomized scoreboard bench: requester queues + round-robin reference model,
// behavioural hash core with programmable latency, decoupled response monitor.
module tb_keccak_hash_arbiter;
  localparam int N   = 4;
  localparam int DW  = 512;
  localparam int HW  = 256;
  localparam int TMO = 64;
  localparam int IDW = 2;

  typedef struct {
    int          id;
    logic [HW-1:0] hash;
    logic        err;
    int          delta;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic [IDW-1:0] grant_id;
  always #5 clk = ~clk;

  keccak_hash_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .HASH_W(HW)) bus ();

  keccak_hash_arbiter #(.NUM_REQ(N), .DATA_W(DW), .HASH_W(HW), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .busy     (busy),
    .grant_id (grant_id)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mptr  = 0;
  int bp_id = -1;
  exp_t exp_q[$];
  int   start_q[$];
  int   lat_q[$];
  int   plan_q[$];
  logic [DW-1:0] blk_q[N][$];
  logic [DW-1:0] mq[N][$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] fake_hash(input logic [DW-1:0] d);
    return d[511:256] ^ {d[242:0], d[255:243]} ^ {8{32'h9e3779b9}};
  endfunction

  function automatic logic [DW-1:0] rnd_blk();
    logic [DW-1:0] r;
    for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int rnd_lat();
    case ($urandom_range(0, 9))
      0:       return TMO;
      1:       return TMO + 1;
      2:       return 0;
      3:       return TMO - 1;
      default: return $urandom_range(1, 20);
    endcase
  endfunction

  function automatic bit any_blk();
    for (int i = 0; i < N; i++) if (blk_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_mq();
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_req(input int id, input logic [DW-1:0] d);
    blk_q[id].push_back(d);
    mq[id].push_back(d);
  endtask

  // Reference: repeatedly serve the first non-empty requester at/after mptr.
  task automatic schedule();
    int i, lat;
    exp_t e;
    logic [DW-1:0] d;
    while (any_mq()) begin
      i = mptr;
      for (int k = 0; k < N; k++) begin
        i = (mptr + k) % N;
        if (mq[i].size() != 0) break;
      end
      d    = mq[i].pop_front();
      lat  = (plan_q.size() != 0) ? plan_q.pop_front() : rnd_lat();
      mptr = (i + 1) % N;
      e.id    = i;
      e.err   = (lat == 0) || (lat > TMO);
      e.hash  = e.err ? '0 : fake_hash(d);
      e.delta = (e.err ? TMO : lat) + 1;
      exp_q.push_back(e);
      lat_q.push_back(lat);
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || any_blk()) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_budget"}, DW'(n < 3000), DW'(1));
    repeat (2) @(posedge clk);
    #2;
    chk({nm, "_lat_left"}, DW'(lat_q.size()), '0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req_ready"},  DW'(bus.req_ready),  '0);
    chk({nm, "_rsp_valid"},  DW'(bus.rsp_valid),  '0);
    chk({nm, "_rsp_hash"},   DW'(bus.rsp_hash),   '0);
    chk({nm, "_rsp_err"},    DW'(bus.rsp_err),    '0);
    chk({nm, "_core_start"}, DW'(bus.core_start), '0);
    chk({nm, "_core_data"},  bus.core_data,       '0);
    chk({nm, "_busy"},       DW'(busy),           '0);
    chk({nm, "_grant_id"},   DW'(grant_id),       '0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: present queue heads; a handshake seen before the edge pops after it.
  initial begin
    logic [N-1:0]  pend;
    logic [DW-1:0] tmp;
    pend = '0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (pend[i] && blk_q[i].size() != 0) tmp = blk_q[i].pop_front();
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = (blk_q[i].size() != 0);
        bus.req_data[i*DW +: DW] = (blk_q[i].size() != 0) ? blk_q[i][0] : '0;
      end
      #1;
      pend = rst_n ? (bus.req_valid & bus.req_ready) : '0;
      if (rst_n) begin
        chk("ready_onehot", DW'($countones(bus.req_ready) <= 1), DW'(1));
        chk("ready_subset", DW'(bus.req_ready & ~bus.req_valid), '0);
      end
    end
  end

  // Hash core: latency 0 means never done; stray done pulses while idle.
  initial begin
    logic [DW-1:0] blk;
    int lat, wait_n;
    bit aborted;
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.core_start) begin
        bus.core_done = 1'b0;
        blk = bus.core_data;
        start_q.push_back(cyc);
        if (lat_q.size() != 0) lat = lat_q.pop_front();
        else begin
          chk("core_unplanned_start", DW'(1), '0);
          lat = 1;
        end
        wait_n  = (lat == 0) ? TMO + 1 : lat;
        aborted = 1'b0;
        for (int k = 0; k < wait_n; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted && lat != 0) begin
          chk("core_data_stable", bus.core_data, blk);
          bus.core_done = 1'b1;
          bus.core_hash = fake_hash(blk);
          @(negedge clk);
          bus.core_done = 1'b0;
        end
      end else begin
        bus.core_done = rst_n && ($urandom_range(0, 7) == 0);
        bus.core_hash = {8{$urandom}};
      end
    end
  end

  // Response monitor: pops the scoreboard on each new rsp_valid, applies backpressure.
  initial begin
    bit in_rsp, hs, prev_start;
    logic [HW-1:0] last_hash;
    logic          last_err;
    logic [N-1:0]  last_vld;
    int hold, st, eid;
    exp_t e;
    in_rsp = 0; hs = 0; prev_start = 0; hold = 0;
    last_hash = '0; last_err = 0; last_vld = '0;
    bus.rsp_ready = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_rsp = 0; hs = 0; prev_start = 0;
        bus.rsp_ready = '0;
        chk("rst_rsp_valid", DW'(bus.rsp_valid), '0);
        continue;
      end
      if (hs) begin
        in_rsp = 0; hs = 0;
        chk("rsp_after_hs", DW'(bus.rsp_valid), '0);
      end
      if (prev_start) chk("start_pulse", DW'(bus.core_start), '0);
      prev_start = bus.core_start;
      if (busy) chk("ready_while_busy", DW'(bus.req_ready), '0);
      if (bus.rsp_valid != '0) begin
        if (!in_rsp) begin
          in_rsp = 1;
          eid = -1;
          if (exp_q.size() == 0) chk("unexpected_rsp", DW'(bus.rsp_valid), '0);
          else begin
            e   = exp_q.pop_front();
            eid = e.id;
            chk("rsp_onehot", DW'(bus.rsp_valid), DW'(1 << e.id));
            chk("grant_id",   DW'(grant_id),      DW'(e.id));
            chk("rsp_hash",   DW'(bus.rsp_hash),  DW'(e.hash));
            chk("rsp_err",    DW'(bus.rsp_err),   DW'(e.err));
            st = (start_q.size() != 0) ? start_q.pop_front() : -100000;
            chk("rsp_latency", DW'(cyc - st), DW'(e.delta));
          end
          last_hash = bus.rsp_hash;
          last_err  = bus.rsp_err;
          last_vld  = bus.rsp_valid;
          hold = (eid >= 0 && eid == bp_id) ? 10 : $urandom_range(0, 3);
        end else begin
          chk("hash_stable", DW'(bus.rsp_hash),  DW'(last_hash));
          chk("err_stable",  DW'(bus.rsp_err),   DW'(last_err));
          chk("vld_stable",  DW'(bus.rsp_valid), DW'(last_vld));
        end
        if (hold == 0) begin
          bus.rsp_ready = bus.rsp_valid | N'($urandom);
          hs = 1;
        end else begin
          hold--;
          bus.rsp_ready = N'($urandom) & ~bus.rsp_valid;
        end
      end else begin
        bus.rsp_ready = N'($urandom);
      end
    end
  end

  initial begin
    int cnt;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    rst_n = 1'b1;

    // single request on requester 2
    plan_q.push_back(26);
    add_req(2, {64{8'hA5}});
    schedule();
    wait_done("single");

    // all requesters busy, core latency 5
    for (int t = 0; t < 8; t++) plan_q.push_back(5);
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_req(i, rnd_blk());
    schedule();
    wait_done("contend");

    // requester 1 response held off for 10 cycles
    bp_id = 1;
    plan_q.push_back(3);
    plan_q.push_back(3);
    add_req(1, rnd_blk());
    add_req(2, rnd_blk());
    schedule();
    wait_done("backpressure");
    bp_id = -1;

    // watchdog abort followed by a normal transaction; late done ignored
    plan_q.push_back(0);
    plan_q.push_back(7);
    plan_q.push_back(TMO + 1);
    plan_q.push_back(4);
    add_req(0, rnd_blk());
    add_req(1, rnd_blk());
    add_req(2, rnd_blk());
    add_req(3, rnd_blk());
    schedule();
    wait_done("timeout");

    // done in the last WAIT cycle wins over timeout
    plan_q.push_back(TMO);
    plan_q.push_back(TMO - 1);
    add_req(3, rnd_blk());
    add_req(0, rnd_blk());
    schedule();
    wait_done("edge_done");

    // reset while waiting on the core; that result must never surface
    blk_q[3].push_back(rnd_blk());
    lat_q.push_back(40);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy", DW'(busy), DW'(1));
    #1 rst_n = 1'b0;
    #1;
    chk_zero("mid_reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("mid_reset_held");
    lat_q.delete();
    start_q.delete();
    exp_q.delete();
    mptr = 0;
    #1 rst_n = 1'b1;
    for (int t = 0; t < 5; t++) plan_q.push_back(5);
    add_req(0, rnd_blk());
    add_req(0, rnd_blk());
    add_req(1, rnd_blk());
    add_req(2, rnd_blk());
    add_req(3, rnd_blk());
    schedule();
    wait_done("post_reset");

    // random batches
    for (int b = 0; b < 6; b++) begin
      cnt = $urandom_range(1, 8);
      for (int t = 0; t < cnt; t++) add_req($urandom_range(0, N - 1), rnd_blk());
      schedule();
      wait_done("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
